// File: rtl/uart_parity_tx.sv
// uart_parity_tx: byte-wide UART transmitter with parity and a small write FIFO.
//
// One clk cycle equals one UART bit period. Bytes are queued on flag_start,
// then sent as 1 start bit, 8 data bits (LSB first), 1 parity bit and
// STOP_BITS stop bits. Queued frames are sent back-to-back with no idle gap.
//
// Parameters:
//   PARITY_ODD  0 = even parity, 1 = odd parity
//   STOP_BITS   stop bits per frame (1 or 2)
//   DEPTH       FIFO entries (power of two, 2..16)
//
// Ports:
//   clk         bit clock, rising edge
//   rst_n       asynchronous active-low reset
//   data        byte to queue
//   flag_start  write strobe, one entry per cycle while high
//   inject_err  queued with data; inverts that frame's parity bit
//   out         registered serial line, idles high
//   busy        high while a frame is on the line
//   fifo_full   FIFO holds DEPTH entries
//   overflow    one-cycle pulse after a write was dropped because of full
module uart_parity_tx #(
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       flag_start,
    input  logic       inject_err,
    output logic       out,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int   AW        = $clog2(DEPTH);
    localparam logic ODD_BIT   = (PARITY_ODD != 0);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    // ------------------------------------------------------------------
    // FIFO: entry = {inject_err, data}. Pointers carry one extra wrap bit
    // so full and empty are told apart without a counter.
    // ------------------------------------------------------------------
    logic [8:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, push, pop;
    logic [8:0]  head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A write into a full FIFO is dropped even if a pop frees a slot on
    // the same edge; full is judged on the pre-edge state.
    assign push  = flag_start && !full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {inject_err, data};
    end

    // ------------------------------------------------------------------
    // Transmit FSM. state_q names the bit currently driven on out_q.
    // ------------------------------------------------------------------
    state_e     state_q;
    logic       out_q, busy_q, overflow_q;
    logic [7:0] sh_q;       // frame byte, held for the whole frame
    logic       par_q;      // parity bit, fixed when the entry is popped
    logic [2:0] idx_q;      // data bit index, wraps 7->0 into PARITY
    logic [2:0] idx_nxt;
    logic       stop_cnt_q;
    logic       stop_last;

    assign idx_nxt   = idx_q + 3'd1;
    assign stop_last = (stop_cnt_q == STOP_LAST);
    // Pop from idle, or on the last stop bit so the next start bit follows
    // without a gap.
    assign pop = !empty && (state_q == IDLE || (state_q == STOP && stop_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            sh_q       <= '0;
            par_q      <= 1'b0;
            idx_q      <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            overflow_q <= flag_start && full;
            if (pop) begin
                state_q <= START;
                out_q   <= 1'b0;
                busy_q  <= 1'b1;
                sh_q    <= head[7:0];
                par_q   <= (^head[7:0]) ^ ODD_BIT ^ head[8];
            end else begin
                case (state_q)
                    IDLE: begin
                        out_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    START: begin
                        state_q <= DATA;
                        out_q   <= sh_q[0];
                        idx_q   <= 3'd0;
                    end
                    DATA: begin
                        idx_q <= idx_nxt;
                        if (idx_q == 3'd7) begin
                            state_q <= PARITY;
                            out_q   <= par_q;
                        end else begin
                            out_q <= sh_q[idx_nxt];
                        end
                    end
                    PARITY: begin
                        state_q    <= STOP;
                        out_q      <= 1'b1;
                        stop_cnt_q <= 1'b0;
                    end
                    STOP: begin
                        out_q <= 1'b1;
                        if (stop_last) begin
                            // FIFO empty here, otherwise pop would have fired
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        out_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign fifo_full = full;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_parity_tx.sv
// Bench for uart_parity_tx. Three instances share one stimulus stream:
//   dut0: even parity, 1 stop, depth 4
//   dut1: odd parity,  1 stop, depth 2
//   dut2: even parity, 2 stop, depth 16
// The stimulus side predicts, per instance, which writes are accepted and
// the edge on which each frame's start bit appears; a monitor compares the
// line, busy, fifo_full and overflow every cycle against those predictions.
module tb_uart_parity_tx;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic flag_start = 1'b0;
    logic inject_err = 1'b0;
    logic [NDUT-1:0] out_w, busy_w, full_w, ovf_w;

    always #5 clk = ~clk;

    int cyc = 0;        // number of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    uart_parity_tx #(.PARITY_ODD(0), .STOP_BITS(1), .DEPTH(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data(data), .flag_start(flag_start),
        .inject_err(inject_err), .out(out_w[0]), .busy(busy_w[0]),
        .fifo_full(full_w[0]), .overflow(ovf_w[0]));
    uart_parity_tx #(.PARITY_ODD(1), .STOP_BITS(1), .DEPTH(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data(data), .flag_start(flag_start),
        .inject_err(inject_err), .out(out_w[1]), .busy(busy_w[1]),
        .fifo_full(full_w[1]), .overflow(ovf_w[1]));
    uart_parity_tx #(.PARITY_ODD(0), .STOP_BITS(2), .DEPTH(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data(data), .flag_start(flag_start),
        .inject_err(inject_err), .out(out_w[2]), .busy(busy_w[2]),
        .fifo_full(full_w[2]), .overflow(ovf_w[2]));

    function automatic int p_odd(input int k);   return (k == 1) ? 1 : 0;  endfunction
    function automatic int p_stop(input int k);  return (k == 2) ? 2 : 1;  endfunction
    function automatic int p_depth(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 16);
    endfunction

    // Frame as the sequence of line bits: index 0 = start bit.
    function automatic logic [11:0] mk_frame(input int k, input logic [7:0] d, input logic e);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        f[9]   = (^d) ^ (p_odd(k) != 0) ^ e;
        return f;
    endfunction

    typedef struct {
        int          start;
        logic [11:0] bits;
    } frame_t;

    typedef struct {
        int   k;
        int   at;
        logic b;
    } lit_t;

    frame_t exp_q[NDUT][$];   // predicted frames, in line order
    int     drop_q[NDUT][$];  // edges at which a write is dropped
    int     pend[NDUT][$];    // start edges of accepted, not yet sent frames
    int     last_end[NDUT];   // first edge after the last predicted frame
    lit_t   lit_q[$];         // hand-written line values for directed frames

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int k, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d edge %0d: got %b expected %b", nm, k, cyc, act, exp);
        end
    endtask

    // Reference: a write at edge n is accepted unless DEPTH entries are
    // waiting (start edge >= n). An accepted frame starts one edge after
    // the write, or right when the previous frame ends.
    task automatic model_edge(input int k, input logic [7:0] d, input logic e);
        int n;
        int s;
        frame_t f;
        n = cyc + 1;
        while (pend[k].size() > 0 && pend[k][0] < n) void'(pend[k].pop_front());
        if (pend[k].size() == p_depth(k)) begin
            drop_q[k].push_back(n);
        end else begin
            s = (n + 1 > last_end[k]) ? n + 1 : last_end[k];
            f.start = s;
            f.bits  = mk_frame(k, d, e);
            exp_q[k].push_back(f);
            pend[k].push_back(s);
            last_end[k] = s + 10 + p_stop(k);
        end
    endtask

    // Called 2ns after a falling edge; drives inputs for the next rising edge.
    task automatic step(input logic fs, input logic [7:0] d, input logic e);
        flag_start = fs;
        data       = d;
        inject_err = e;
        if (fs && rst_n)
            for (int k = 0; k < NDUT; k++) model_edge(k, d, e);
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        flag_start = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            exp_q[k].delete();
            drop_q[k].delete();
            pend[k].delete();
            last_end[k] = 0;
        end
        @(negedge clk); #2;
        @(negedge clk); #2;
        rst_n = 1'b1;
    endtask

    // Directed frame on an idle block: write lands on the next edge and the
    // start bit follows one edge later.
    task automatic lit_frame(input int k, input logic [7:0] d, input logic e,
                             input logic [11:0] pat, input int len);
        lit_t l;
        for (int i = 0; i < len; i++) begin
            l.k  = k;
            l.at = cyc + 2 + i;
            l.b  = pat[i];
            lit_q.push_back(l);
        end
        step(1'b1, d, e);
    endtask

    // Monitor
    initial begin : monitor
        frame_t cur[NDUT];
        bit     cur_v[NDUT];
        int     idx;
        logic   eo, eb, ef, eov;
        lit_t   l;
        for (int k = 0; k < NDUT; k++) cur_v[k] = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            for (int k = 0; k < NDUT; k++) begin
                if (!rst_n) begin
                    cur_v[k] = 1'b0;
                    chk("reset_out", k, out_w[k], 1'b1);
                    chk("reset_busy", k, busy_w[k], 1'b0);
                    chk("reset_full", k, full_w[k], 1'b0);
                    chk("reset_ovf", k, ovf_w[k], 1'b0);
                end else begin
                    if (!cur_v[k] && exp_q[k].size() > 0 && exp_q[k][0].start == cyc) begin
                        cur[k]   = exp_q[k].pop_front();
                        cur_v[k] = 1'b1;
                    end
                    idx = 0;
                    if (cur_v[k]) begin
                        idx = cyc - cur[k].start;
                        eo  = cur[k].bits[idx];
                        eb  = 1'b1;
                    end else begin
                        eo = 1'b1;
                        eb = 1'b0;
                    end
                    chk("line", k, out_w[k], eo);
                    chk("busy", k, busy_w[k], eb);
                    if (cur_v[k] && idx == 9 + p_stop(k)) cur_v[k] = 1'b0;
                    ef = (exp_q[k].size() == p_depth(k));
                    chk("fifo_full", k, full_w[k], ef);
                    eov = 1'b0;
                    if (drop_q[k].size() > 0 && drop_q[k][0] == cyc) begin
                        eov = 1'b1;
                        void'(drop_q[k].pop_front());
                    end
                    chk("overflow", k, ovf_w[k], eov);
                end
            end
            if (rst_n) begin
                while (lit_q.size() > 0 && lit_q[0].at <= cyc) begin
                    l = lit_q.pop_front();
                    if (l.at == cyc) chk("literal_bit", l.k, out_w[l.k], l.b);
                end
            end
        end
    end

    // Stimulus
    initial begin : stim
        @(negedge clk); #2;
        @(negedge clk); #2;
        rst_n = 1'b1;
        idle(3);

        // 0x55 even parity: 0,1,0,1,0,1,0,1,0,0,1
        lit_frame(0, 8'h55, 1'b0, 12'h4AA, 11);
        idle(30);
        // odd parity 0x07: parity 0, then 1 with inject_err
        lit_frame(1, 8'h07, 1'b0, 12'h40E, 11);
        idle(30);
        lit_frame(1, 8'h07, 1'b1, 12'h60E, 11);
        idle(30);
        // two stop bits, 0xFF: 0, eight 1s, parity 0, 1, 1
        lit_frame(2, 8'hFF, 1'b0, 12'hDFE, 12);
        idle(30);

        // six consecutive writes: sixth hits a full depth-4 FIFO
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'(i));
        idle(100);

        // strobe held for three cycles
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        step(1'b1, 8'hA3, 1'b0);
        idle(50);

        // reset during data bit 4 with two entries queued
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'hC3, 1'b1);
        step(1'b1, 8'h5A, 1'b0);
        idle(4);
        do_reset();
        step(1'b1, 8'h96, 1'b0);
        idle(20);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) do_reset();
            else step($urandom_range(99) < 30, 8'($urandom), 1'($urandom));
        end
        idle(250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
